word_deframer: RTL and testbench



---
 rtl/deframer_pkg.sv | 22 ++
 rtl/word_deframer_bit_sync.sv | 31 +++
 rtl/word_deframer.sv | 139 +++++++++++++
 tb/tb_word_deframer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deframer_pkg
// Description : Shared types and framing constants for the serial word deframer.
// Revision    : 1.0 - initial release
// ============================================================================
package deframer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DATA_BITS_DEFAULT = 10;
    localparam int   FRAME_BITS        = DATA_BITS_DEFAULT + 2;
    localparam logic START_LVL         = 1'b0;
    localparam logic STOP_LVL          = 1'b1;

endpackage
`default_nettype wire

// File: rtl/word_deframer_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Two-flop synchronizer for the asynchronous rx line; resets to
//               the idle-high level so no false start appears out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/word_deframer.sv
`default_nettype none
// ============================================================================
// Module      : word_deframer
// Description : Oversampling receiver for start/10-bit-LSB-first/stop frames;
//               samples mid-bit and strobes each good word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_deframer
    import deframer_pkg::*;
#(
    parameter int OS        = 16,
    parameter int DATA_BITS = FRAME_BITS - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                CNT_W      = $clog2(OS);
    localparam logic [CNT_W-1:0]  c_HALF     = CNT_W'(OS / 2 - 1);
    localparam logic [CNT_W-1:0]  c_FULL     = CNT_W'(OS - 1);
    localparam logic [3:0]        c_LAST_IDX = 4'(DATA_BITS - 1);

    logic                 w_rx_s;
    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [3:0]           r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_armed, w_armed_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_err, w_err_nxt;

    bit_sync u_bit_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_armed <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_armed <= w_armed_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_armed_nxt = r_armed;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Arming on a high line keeps a stuck-low input from framing.
                if (w_rx_s == STOP_LVL) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = (w_rx_s == START_LVL) ? DATA : IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == c_FULL) begin
                    // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nxt   = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == c_FULL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s == STOP_LVL) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_armed_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_word_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_deframer
// Description : Self-checking bench for word_deframer: vector table plus
//               scoreboard of expected pulses with their exact cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_deframer;
    import deframer_pkg::*;

    localparam int OS  = 16;
    localparam int DB  = 10;
    localparam int LAT = 1 + 2 + OS / 2 + (DB + 1) * OS;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          rx_in = 1'b1;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    word_deframer #(.OS(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          is_err;
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [DB-1:0] d;
        logic          stop;
        int            gap;
        logic          exp_err;
        logic [DB-1:0] exp_data;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort_at >= 0 pulses rst on that clock of the frame and releases the line.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int abort_at);
        logic [DB+1:0] f;
        f = {stop, d, START_LVL};
        for (int k = 0; k < (DB + 2) * OS; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst   = 1'b0;
                rx_in = 1'b1;
                return;
            end
            rx_in = f[k / OS];
            tick();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (data_valid || frame_err) begin
            check("valid_err_exclusive", {31'b0, data_valid & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {31'b0, frame_err}, {31'b0, ~frame_err & ~data_valid});
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {31'b0, frame_err}, {31'b0, e.is_err});
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_data", {22'b0, data}, {22'b0, e.data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{d: 10'h2A5, stop: 1'b1, gap: 2, exp_err: 1'b0, exp_data: 10'h2A5};
        vecs[1] = '{d: 10'h000, stop: 1'b1, gap: 2, exp_err: 1'b0, exp_data: 10'h000};
        vecs[2] = '{d: 10'h001, stop: 1'b1, gap: 0, exp_err: 1'b0, exp_data: 10'h001};
        vecs[3] = '{d: 10'h3FF, stop: 1'b1, gap: 0, exp_err: 1'b0, exp_data: 10'h3FF};
        vecs[4] = '{d: 10'h155, stop: 1'b0, gap: 2, exp_err: 1'b1, exp_data: 10'h3FF};

        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_data", {22'b0, data}, 32'd0);
        repeat (100) tick();
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_data", {22'b0, data}, 32'd0);
        check("idle_pulses", {30'b0, data_valid, frame_err}, 32'd0);

        foreach (vecs[i]) begin
            rx_in = 1'b1;
            repeat (vecs[i].gap * OS) tick();
            sb.push_back('{is_err: vecs[i].exp_err, data: vecs[i].exp_data, cyc: cyc + LAT});
            send_frame(vecs[i].d, vecs[i].stop, -1);
            check("data_after_frame", {22'b0, data}, {22'b0, vecs[i].exp_data});
        end

        // Line stays low after the bad stop: disarmed, so nothing may start.
        rx_in = 1'b0;
        repeat (2 * OS) tick();
        check("disarmed_busy", {31'b0, busy}, 32'd0);
        rx_in = 1'b1;
        repeat (OS) tick();
        sb.push_back('{is_err: 1'b0, data: 10'h19C, cyc: cyc + LAT});
        send_frame(10'h19C, 1'b1, -1);
        check("rearm_data", {22'b0, data}, 32'h19C);

        // Five-clock low glitch on idle line.
        rx_in = 1'b1;
        repeat (OS) tick();
        rx_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 5)  rx_in = 1'b1;
            if (i == 10) check("glitch_busy_hi", {31'b0, busy}, 32'd1);
            if (i == 11) check("glitch_busy_lo", {31'b0, busy}, 32'd0);
        end
        check("glitch_data", {22'b0, data}, 32'h19C);

        // Reset in the middle of a frame.
        repeat (OS) tick();
        send_frame(10'h2A5, 1'b1, 100);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_data", {22'b0, data}, 32'd0);
        repeat (2 * OS) tick();
        check("abort_idle_busy", {31'b0, busy}, 32'd0);
        sb.push_back('{is_err: 1'b0, data: 10'h0F0, cyc: cyc + LAT});
        send_frame(10'h0F0, 1'b1, -1);
        check("post_abort_data", {22'b0, data}, 32'h0F0);

        rx_in = 1'b1;
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
